// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the decoder-side handshake of fetch_unit.
// master is the fetch unit's view; slave is the memory/decoder side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i, halt_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i, halt_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a small output buffer, redirect and halt.
// Define FETCH_BUF2_EN for a 2-entry output buffer (default is 1 entry).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_unit_if.master bus
);

`ifdef FETCH_BUF2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] tag_pc, tag_pc_n;
  logic        drop, drop_n;
  logic        halt_pend, halt_pend_n;

  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_n;

  logic req, grant, resp, flush, push, pop;

  // Requests are only made when the buffer can absorb the response, never in a redirect/halt cycle.
  assign req   = !rst_i && (state == RUN) && (count < DEPTH) && !bus.redirect_i && !bus.halt_i;
  assign grant = req && bus.imem_gnt_i;
  assign resp  = (state == WAIT) && bus.imem_rvalid_i;
  assign flush = bus.redirect_i;
  assign push  = resp && !drop && !flush;
  assign pop   = (count != 2'd0) && bus.instr_ready_i && !flush;

  assign count_n = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    tag_pc_n    = tag_pc;
    drop_n      = drop;
    halt_pend_n = halt_pend;

    case (state)
      RUN: begin
        if (grant) begin
          state_n    = WAIT;
          tag_pc_n   = fetch_pc;
          fetch_pc_n = fetch_pc + 32'd4;
        end else if (bus.halt_i) begin
          state_n = HALT;
        end
      end
      WAIT: begin
        if (resp) begin
          state_n     = (halt_pend || bus.halt_i) ? HALT : RUN;
          drop_n      = 1'b0;
          halt_pend_n = 1'b0;
        end else if (bus.halt_i) begin
          halt_pend_n = 1'b1;
        end
      end
      HALT: ;
      default: state_n = RUN;
    endcase

    // A redirect overrides everything, including a coincident halt; an in-flight response gets dropped.
    if (bus.redirect_i) begin
      fetch_pc_n  = {bus.redirect_pc_i[31:2], 2'b00};
      halt_pend_n = 1'b0;
      if (state == WAIT && !bus.imem_rvalid_i) begin
        state_n = WAIT;
        drop_n  = 1'b1;
      end else begin
        state_n = RUN;
        drop_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      tag_pc    <= RESET_PC;
      drop      <= 1'b0;
      halt_pend <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      tag_pc    <= tag_pc_n;
      drop      <= drop_n;
      halt_pend <= halt_pend_n;
      count     <= count_n;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= (DEPTH == 2'd2) ? ~wr_ptr : 1'b0;
        if (pop)  rd_ptr <= (DEPTH == 2'd2) ? ~rd_ptr : 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      buf_instr[wr_ptr] <= bus.imem_rdata_i;
      buf_pc[wr_ptr]    <= tag_pc;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = rst_i ? RESET_PC : fetch_pc;
  assign bus.instr_valid_o = !rst_i && (count != 2'd0);
  assign bus.instr_o       = rst_i ? 32'h0 : buf_instr[rd_ptr];
  assign bus.pc_o          = rst_i ? 32'h0 : buf_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized plus directed bench for fetch_unit against a queue-based instruction-stream model.
// Honours FETCH_BUF2_EN the same way as the design.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Words the decoder should still see, oldest first.
  entry_t      q[$];
  logic [31:0] grant_log[$];
  logic [31:0] deliv_log[$];

  int          checks = 0;
  int          passed = 0;
  int          deliveries = 0;

  logic [31:0] fetch_pc_m;
  bit          outstanding, stale, halted;
  logic [31:0] resp_addr;
  int          resp_wait;
  int          lat_min = 0;
  int          lat_max = 2;
  int          gnt_pct = 70;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %08h, expected %08h at %0t", tag, got, exp, $time);
  endtask

  // Compares outputs with the model just before the edge, then advances the model by that edge.
  task automatic observe(input bit rdy, input bit redir, input logic [31:0] rpc, input bit hlt, input bit rs);
    bit     exp_req;
    bit     took;
    entry_t e;
    if (rs) begin
      checkOutput("rst_req", bus.imem_req_o, 0);
      checkOutput("rst_addr", bus.imem_addr_o, RESET_PC);
      checkOutput("rst_valid", bus.instr_valid_o, 0);
      checkOutput("rst_instr", bus.instr_o, 0);
      checkOutput("rst_pc", bus.pc_o, 0);
      q.delete();
      fetch_pc_m  = RESET_PC;
      outstanding = 0;
      stale       = 0;
      halted      = 0;
      return;
    end
    exp_req = !outstanding && !halted && (q.size() < DEPTH) && !redir && !hlt;
    checkOutput("imem_req", bus.imem_req_o, exp_req);
    if (bus.imem_req_o) checkOutput("imem_addr", bus.imem_addr_o, fetch_pc_m);
    checkOutput("instr_valid", bus.instr_valid_o, q.size() != 0);
    if (bus.instr_valid_o && q.size() != 0) begin
      checkOutput("instr", bus.instr_o, q[0].instr);
      checkOutput("pc", bus.pc_o, q[0].pc);
    end
    if (bus.instr_valid_o && rdy && !redir && q.size() != 0) begin
      deliv_log.push_back(q[0].pc);
      void'(q.pop_front());
      deliveries++;
    end
    took = 0;
    if (outstanding && bus.imem_rvalid_i) begin
      if (!stale && !redir) begin
        e.instr = memWord(resp_addr);
        e.pc    = resp_addr;
        q.push_back(e);
      end
      outstanding = 0;
      stale       = 0;
      took        = 1;
    end
    if (bus.imem_req_o && bus.imem_gnt_i) begin
      grant_log.push_back(bus.imem_addr_o);
      outstanding = 1;
      stale       = 0;
      resp_addr   = bus.imem_addr_o;
      resp_wait   = $urandom_range(lat_max, lat_min);
      fetch_pc_m  = fetch_pc_m + 32'd4;
    end else if (outstanding && !took && resp_wait > 0) begin
      resp_wait--;
    end
    if (redir) begin
      q.delete();
      fetch_pc_m = {rpc[31:2], 2'b00};
      halted     = 0;
      if (outstanding) stale = 1;
    end else if (hlt) begin
      halted = 1;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check before the next one.
  task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] rpc, input bit hlt, input bit rs);
    rst               = rs;
    bus.instr_ready_i = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.halt_i        = hlt;
    bus.imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    if (outstanding && resp_wait == 0) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = stale ? 32'hDEAD_BEEF : memWord(resp_addr);
    end else begin
      bus.imem_rvalid_i = !outstanding && ($urandom_range(9) == 0);
      bus.imem_rdata_i  = $urandom;
    end
    #4;
    observe(rdy, redir, rpc, hlt, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(rdy, 0, 32'h0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    logic [31:0] head_instr, head_pc;
    rst = 1'b1;
    bus.instr_ready_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0; bus.halt_i = 0;
    bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = 0;
    @(posedge clk);
    #1;

    // Straight-line fetch with immediate grant and one-cycle response.
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    doReset();
    deliv_log.delete();
    idle(12, 1);
    checkOutput("seq_len", deliv_log.size() >= 3, 1);
    for (int i = 0; i < 3; i++)
      if (deliv_log.size() > i) checkOutput("seq_pc", deliv_log[i], 32'(4 * i));

    // Redirect while a response is in flight; the late word must be dropped.
    lat_min = 2; lat_max = 2;
    doReset();
    idle(1, 1);
    checkOutput("drop_inflight", outstanding, 1);
    applyStimulus(1, 1, 32'h0000_0103, 0, 0);
    grant_log.delete(); deliv_log.delete();
    idle(12, 1);
    checkOutput("drop_grant_len", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) checkOutput("drop_next_addr", grant_log[0], 32'h100);
    checkOutput("drop_deliv_len", deliv_log.size() >= 1, 1);
    if (deliv_log.size() >= 1) checkOutput("drop_first_pc", deliv_log[0], 32'h100);

    // Downstream stall: head held, buffer fills to its depth and no further.
    lat_min = 0; lat_max = 0;
    doReset();
    for (int i = 0; i < 10 && !bus.instr_valid_o; i++) applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("stall_reach_valid", bus.instr_valid_o, 1);
    head_instr = bus.instr_o;
    head_pc    = bus.pc_o;
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 0);
      checkOutput("stall_valid", bus.instr_valid_o, 1);
      checkOutput("stall_instr", bus.instr_o, head_instr);
      checkOutput("stall_pc", bus.pc_o, head_pc);
    end
    checkOutput("stall_grants", grant_log.size(), DEPTH - 1);

    // Halt while fetching 0x8, then resume via redirect.
    lat_min = 1; lat_max = 1;
    doReset();
    for (int i = 0; i < 40 && !(outstanding && resp_addr == 32'h8); i++) applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("halt_reach_pc8", outstanding && resp_addr == 32'h8, 1);
    applyStimulus(1, 0, 32'h0, 1, 0);
    grant_log.delete(); deliv_log.delete();
    idle(10, 1);
    checkOutput("halt_grants", grant_log.size(), 0);
    checkOutput("halt_deliv_len", deliv_log.size() >= 1, 1);
    if (deliv_log.size() >= 1) checkOutput("halt_last_pc", deliv_log[deliv_log.size() - 1], 32'h8);
    applyStimulus(1, 1, 32'h0000_0040, 0, 0);
    idle(5, 1);
    checkOutput("resume_len", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) checkOutput("resume_addr", grant_log[0], 32'h40);

    // Fetch PC wrap at the top of the address space.
    lat_min = 0; lat_max = 0;
    grant_log.delete();
    applyStimulus(1, 1, 32'hFFFF_FFFC, 0, 0);
    idle(8, 1);
    checkOutput("wrap_len", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      checkOutput("wrap_first", grant_log[0], 32'hFFFF_FFFC);
      checkOutput("wrap_next", grant_log[1], 32'h0);
    end

    // Redirect and halt together: redirect wins.
    grant_log.delete();
    applyStimulus(1, 1, 32'h0000_0200, 1, 0);
    idle(4, 1);
    checkOutput("redir_halt_len", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) checkOutput("redir_halt_addr", grant_log[0], 32'h200);

    // Random traffic with occasional redirects, halts and resets.
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    deliveries = 0;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 70,
                    $urandom_range(99) < 3,
                    $urandom,
                    $urandom_range(99) < 3,
                    $urandom_range(999) < 5);
    end
    checkOutput("random_liveness", deliveries > 100, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
